tlb_refill_ctrl: RTL
====================

Name: tlb_refill_ctrl

Overview:
- Sequential owner of TLB replacement state for an 8-way fully associative TLB.
- Holds the per-way valid bits and the 7-node tree-PLRU state; updates PLRU on hits and refills.
- Sequences a miss through a page-table-walker (PTW) request/response handshake, then issues a single-cycle entry write to the victim way.
- Sits between the TLB lookup array and the PTW.

Parameters:
VPN_W, 27, virtual page number width
PTE_W, 64, page table entry payload width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lookup_valid  in  1  lookup performed this cycle
lookup_hit  in  1  lookup hit
lookup_hit_way  in  3  way that hit
lookup_vpn  in  VPN_W  VPN of lookup
miss_ready  out  1  controller idle, can accept a miss
flush  in  1  invalidate all entries (sfence)
ptw_req_valid  out  1  walk request valid
ptw_req_ready  in  1  PTW accepts request
ptw_req_vpn  out  VPN_W  VPN to walk
ptw_resp_valid  in  1  walk result valid
ptw_resp_err  in  1  walk faulted
ptw_resp_pte  in  PTE_W  walk result
tlb_wen  out  1  entry write strobe
tlb_waddr  out  3  way written
tlb_wvpn  out  VPN_W  tag written
tlb_wpte  out  PTE_W  data written
refill_fault  out  1  one-cycle pulse on faulted walk
valid  out  8  per-way valid bits
plru_val  out  8  PLRU nodes; bits 1..7 used, bit 0 always 0

Behaviour:
- Clock and reset: clk, rst_n. rst_n is synchronous and active-low.
- Reset values:
  - State IDLE.
  - valid=0, plru_val=0, ptw_req_valid=0, tlb_wen=0, refill_fault=0, kill flag=0.
  - Captured vpn/pte registers=0.
  - miss_ready=1.
  - Reset mid-operation abandons any walk with no write.
- Victim selection (combinational from current valid/plru_val):
  - If any valid bit is 0, the victim is the lowest-index invalid way.
  - Otherwise walk the tree: n=1; repeat 3 times: n=2n+plru_val[n]; victim=n-8.
- Touch(w) updates nodes: node1=~w[2]; node(2+w[2])=~w[1]; node(4+w[2:1])=~w[0]. All other nodes are unchanged.
- Hits: lookup_valid&lookup_hit in any state touches lookup_hit_way the next edge, unless a write or flush occurs that cycle.
- States:
  - IDLE:
    - miss_ready=1.
    - lookup_valid&~lookup_hit&~flush captures lookup_vpn and moves to REQ.
    - A miss in the same cycle as flush is dropped.
  - REQ:
    - ptw_req_valid=1, ptw_req_vpn=captured vpn. Both are held stable until ptw_req_ready; the request is never withdrawn.
    - On ready, go to WAIT.
  - WAIT:
    - On ptw_resp_valid, capture pte/err and go to WRITE.
    - If the kill flag is set, go to IDLE instead and discard the response.
  - WRITE (exactly one cycle):
    - err=0: tlb_wen=1, tlb_waddr=victim, tlb_wvpn/tlb_wpte=captured. valid[victim] is set and victim is touched next edge.
    - err=1: tlb_wen=0, refill_fault=1; valid and plru_val unchanged.
    - Always returns to IDLE.
- Misses are ignored outside IDLE (miss_ready=0). The TLB replays the miss later.
- Flush:
  - valid and plru_val are cleared next edge in all states.
  - In REQ or WAIT, flush sets the kill flag; the walk completes its handshake and is discarded.
  - In WRITE, flush suppresses tlb_wen and refill_fault.
  - The kill flag clears on entering IDLE.
- Simultaneous hit touch and refill write: the refill touch wins and the hit touch is dropped.
- Latency: miss at cycle 0 → ptw_req_valid at 1. Response at cycle k → tlb_wen at k+1 → miss_ready at k+2.

Decomposition:
- Package tlb_pkg holds:
  - NWAYS=8, WAY_W=3.
  - State enum {IDLE, REQ, WAIT, WRITE}.
  - A plru_touch function (8-bit plru, 3-bit way → 8-bit plru).
- Sub-module tlb_victim_sel: combinational; inputs valid and plru_val; output victim way. This is the victim-selection rule above.

Test Plan:
- Reset, then 8 misses with PTW ready/resp immediate → writes to ways 0..7 in order; valid=8'hFF; plru_val=8'h00; next victim 0.
- From the full state, hit way 0 → plru_val=8'h16; next miss writes way 4.
- Miss with ptw_req_ready low 5 cycles → ptw_req_valid and ptw_req_vpn stable for 6 cycles; miss_ready=0 throughout; single write afterwards.
- Flush asserted during WAIT → response consumed, no tlb_wen, valid=8'h00, plru_val=8'h00, miss_ready=1 the cycle after the response.
- ptw_resp_err=1 → refill_fault pulses exactly 1 cycle; no tlb_wen; valid unchanged.
- Full TLB with plru_val=8'h00: hit way 5 in the same cycle as the WRITE to victim way 0 → only way 0 touched: plru_val=8'h16.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and helpers for the TLB refill controller.
// Way count, FSM states and the tree-PLRU touch rule.
package tlb_pkg;

   localparam int NWAYS = 8;
   localparam int WAY_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      WRITE
   } state_t;

   // Point the three nodes on the path to way away from it.
   function automatic logic [NWAYS-1:0] plru_touch(
      input logic [NWAYS-1:0] plru,
      input logic [WAY_W-1:0] way
   );
      logic [NWAYS-1:0] p;
      p = plru;
      p[1] = ~way[2];
      p[{2'b01, way[2]}] = ~way[1];
      p[{1'b1, way[2:1]}] = ~way[0];
      return p;
   endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Replacement victim for the 8-way TLB.
// Lowest invalid way first, otherwise follow the PLRU tree.
module tlb_victim_sel
   import tlb_pkg::*;
(
   input  logic [NWAYS-1:0] valid,
   input  logic [NWAYS-1:0] plru_val,
   output logic [WAY_W-1:0] victim
);

   logic [3:0] node;

   // Pick the victim way from valid bits and tree state.
   always_comb begin
      victim = '0;
      node   = 4'd1;
      for (int i = NWAYS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            victim = i[WAY_W-1:0];
         end
      end
      if (&valid) begin
         for (int l = 0; l < WAY_W; l++) begin
            node = {node[2:0], plru_val[node[2:0]]};
         end
         victim = node[2:0];
      end
   end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB replacement state owner and miss refill sequencer.
// Runs one page-table walk at a time and writes the victim way.
module tlb_refill_ctrl
   import tlb_pkg::*;
#(
   parameter int VPN_W = 27,
   parameter int PTE_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lookup_valid,
   input  logic             lookup_hit,
   input  logic [WAY_W-1:0] lookup_hit_way,
   input  logic [VPN_W-1:0] lookup_vpn,
   output logic             miss_ready,
   input  logic             flush,
   output logic             ptw_req_valid,
   input  logic             ptw_req_ready,
   output logic [VPN_W-1:0] ptw_req_vpn,
   input  logic             ptw_resp_valid,
   input  logic             ptw_resp_err,
   input  logic [PTE_W-1:0] ptw_resp_pte,
   output logic             tlb_wen,
   output logic [WAY_W-1:0] tlb_waddr,
   output logic [VPN_W-1:0] tlb_wvpn,
   output logic [PTE_W-1:0] tlb_wpte,
   output logic             refill_fault,
   output logic [NWAYS-1:0] valid,
   output logic [NWAYS-1:0] plru_val
);

   state_t state_q, state_d;
   logic [NWAYS-1:0] valid_q, valid_d;
   logic [NWAYS-1:0] plru_q, plru_d;
   logic [VPN_W-1:0] vpn_q, vpn_d;
   logic [PTE_W-1:0] pte_q, pte_d;
   logic err_q, err_d;
   logic kill_q, kill_d;
   logic [WAY_W-1:0] victim;
   logic wen;

   tlb_victim_sel u_victim (
      .valid    (valid_q),
      .plru_val (plru_q),
      .victim   (victim)
   );

   // A write in WRITE is cancelled by a concurrent flush.
   assign wen = (state_q == WRITE) & ~err_q & ~flush;

   assign miss_ready    = (state_q == IDLE);
   assign ptw_req_valid = (state_q == REQ);
   assign ptw_req_vpn   = vpn_q;
   assign tlb_wen       = wen;
   assign tlb_waddr     = victim;
   assign tlb_wvpn      = vpn_q;
   assign tlb_wpte      = pte_q;
   assign refill_fault  = (state_q == WRITE) & err_q & ~flush;
   assign valid         = valid_q;
   assign plru_val      = plru_q;

   // Walk sequencing: capture miss, handshake with PTW, write once.
   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      pte_d   = pte_q;
      err_d   = err_q;
      kill_d  = kill_q;
      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (lookup_valid & ~lookup_hit & ~flush) begin
               vpn_d   = lookup_vpn;
               state_d = REQ;
            end
         end
         REQ: begin
            if (flush) kill_d = 1'b1;
            if (ptw_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (flush) kill_d = 1'b1;
            if (ptw_resp_valid) begin
               pte_d = ptw_resp_pte;
               err_d = ptw_resp_err;
               if (kill_q | flush) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Valid/PLRU update: flush beats refill, refill beats hit.
   always_comb begin
      valid_d = valid_q;
      plru_d  = plru_q;
      if (flush) begin
         valid_d = '0;
         plru_d  = '0;
      end else if (wen) begin
         valid_d = valid_q | (NWAYS'(1) << victim);
         plru_d  = plru_touch(plru_q, victim);
      end else if (lookup_valid & lookup_hit) begin
         plru_d = plru_touch(plru_q, lookup_hit_way);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         plru_q  <= '0;
         vpn_q   <= '0;
         pte_q   <= '0;
         err_q   <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         plru_q  <= plru_d;
         vpn_q   <= vpn_d;
         pte_q   <= pte_d;
         err_q   <= err_d;
         kill_q  <= kill_d;
      end
   end

endmodule
